// File: rtl/breath_pkg.sv
// Mode encoding shared by the breathing-LED array and its bench.
package breath_pkg;
  localparam int MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_BREATH = 2'd0;
  localparam logic [MODE_W-1:0] MODE_SOLID  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_OFF    = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BLINK  = 2'd3;
endpackage

// File: rtl/breath_key_debounce.sv
// Key debouncer: 2-flop synchroniser, then level accepted after DEBOUNCE_CYCLES stable differing cycles.
// key_press is a registered 1-cycle pulse on the accepted rising edge; no backpressure.
module breath_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync      <= '0;
      cnt       <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
    end else begin
      sync      <= {sync[0], key_in};
      key_press <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (sync[1] == key_level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt       <= '0;
        key_level <= sync[1];
        key_press <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/breath_led_array.sv
// N-channel breathing LEDs with staggered phase, key-cycled mode and beep; led registered (1 cycle).
// Optional BREATH_GAMMA_EN squares the level for a perceptually linear fade.
module breath_led_array
  import breath_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int PWM_BITS        = 8,
  parameter int CLK_DIV         = 100,
  parameter int STEP            = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_PERIODS   = 64
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                touch_key,
  output logic [CHANNELS-1:0] led,
  output logic                beep,
  output logic [MODE_W-1:0]   mode
);
  localparam int LVL_W = PWM_BITS + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(2 ** PWM_BITS);

  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink;
  logic                tick;
  logic                period_end;
  logic                key_press;
  logic [CHANNELS-1:0] led_next;

  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign period_end = tick && (pwm_cnt == '1);

  breath_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_in   (touch_key),
    .key_level(),
    .key_press(key_press)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_cnt   <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (period_end) begin
        if (blink_cnt == BLK_W'(BLINK_PERIODS - 1)) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [LVL_W-1:0]        level;
    logic                    dir_down;
    logic [LVL_W-1:0]        duty;
    logic [LVL_W:0]          lvl_up;
    logic signed [LVL_W+1:0] lvl_dn;

    assign lvl_up = {1'b0, level} + (LVL_W + 1)'(STEP);
    assign lvl_dn = $signed({2'b00, level}) - $signed((LVL_W + 2)'(STEP));

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        level    <= LVL_W'((i * (2 ** PWM_BITS)) / CHANNELS);
        dir_down <= 1'b0;
      end else if (period_end) begin
        if (!dir_down) begin
          if (lvl_up >= {1'b0, LVL_MAX}) begin
            level    <= LVL_MAX;
            dir_down <= 1'b1;
          end else begin
            level <= lvl_up[LVL_W-1:0];
          end
        end else if (lvl_dn <= 0) begin
          level    <= '0;
          dir_down <= 1'b0;
        end else begin
          level <= lvl_dn[LVL_W-1:0];
        end
      end
    end

`ifdef BREATH_GAMMA_EN
    logic [2*LVL_W-1:0] sq;
    assign sq   = {{LVL_W{1'b0}}, level} * {{LVL_W{1'b0}}, level};
    assign duty = sq[PWM_BITS +: LVL_W];
`else
    assign duty = level;
`endif

    // Extra top bit lets a full-scale duty stay on for the whole period.
    assign led_next[i] = ({1'b0, pwm_cnt} < duty);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led  <= '0;
      beep <= 1'b0;
      mode <= MODE_BREATH;
    end else begin
      if (key_press) begin
        mode <= mode + MODE_W'(1);
        beep <= ~beep;
      end
      case (mode)
        MODE_BREATH: led <= led_next;
        MODE_SOLID:  led <= '1;
        MODE_OFF:    led <= '0;
        default:     led <= {CHANNELS{blink}};
      endcase
    end
  end
endmodule
